// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory with valid/ready request port,
// fixed-latency response pipeline, alignment/range fault checking and post-reset clear sweep.
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [15:0] fault_count
);

  localparam int WORD_AW = ADDR_W - 2;
  localparam int WORDS   = 2 ** WORD_AW;
  localparam int LAST    = READ_LAT - 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state;
  logic [WORD_AW-1:0] ptr;
  logic [31:0]        mem [WORDS];

  logic               vld_p   [READ_LAT];
  logic               fault_p [READ_LAT];
  logic [31:0]        rdata_p [READ_LAT];

  logic               accept;
  logic               fault_now;
  logic               wr_en;
  logic               rd_en;
  logic [WORD_AW-1:0] widx;
  logic [31:0]        rd_word;
  logic [3:0]         wmask;
  logic [31:0]        wlanes;

  function automatic logic req_fault(input logic [1:0] size, input logic [31:0] addr);
    logic hi;
    hi = (addr >> ADDR_W) != 32'd0;
    case (size)
      2'b00:   req_fault = hi;
      2'b01:   req_fault = hi | addr[0];
      2'b10:   req_fault = hi | (addr[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate the right-justified store data so every candidate lane sees it.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_data = {4{wd[7:0]}};
      2'b01:   lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = sgn ? 32'(b) : {24'd0, b};
      2'b01:   load_extend = sgn ? 32'(h) : {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  assign accept    = req_valid & req_ready;
  assign fault_now = req_fault(req_size, req_addr);
  assign wr_en     = accept & req_write & ~fault_now;
  assign rd_en     = accept & ~req_write & ~fault_now;
  assign widx      = req_addr[ADDR_W-1:2];
  assign rd_word   = mem[widx];
  assign wmask     = lane_mask(req_size, req_addr[1:0]);
  assign wlanes    = lane_data(req_size, req_wdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      req_ready   <= 1'b0;
      fault_count <= '0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + WORD_AW'(1);
          if (&ptr) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          if (accept && fault_now && fault_count != 16'hFFFF)
            fault_count <= fault_count + 16'd1;
        end
      endcase
    end
  end

  // Storage: clear sweep has priority; stores only touch their enabled lanes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end

  // Response pipeline stage 0 loads at accept; later stages shift every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_p[i]   <= 1'b0;
        fault_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0]   <= accept;
      fault_p[0] <= accept & fault_now;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        fault_p[i] <= fault_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    rdata_p[0] <= rd_en ? load_extend(rd_word, req_size, req_addr[1:0], req_signed) : '0;
    for (int i = 1; i < READ_LAT; i++)
      rdata_p[i] <= rdata_p[i-1];
  end

  // Output stage: data and fault are forced to zero whenever no response is present.
  assign rsp_valid = vld_p[LAST];
  assign rsp_fault = vld_p[LAST] & fault_p[LAST];
  assign rsp_rdata = vld_p[LAST] ? rdata_p[LAST] : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one 4 KiB READ_LAT=1 instance plus two small
// instances (READ_LAT 3 and 4) sharing stimulus for pipelining, reset flush and saturation.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b;

  logic        a_valid, a_write, a_signed;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic        a_ready, a_rvld, a_fault;
  logic [31:0] a_rdata;
  logic [15:0] a_fcnt;

  logic        b_valid, b_write, b_signed;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic        b_ready, b_rvld, b_fault;
  logic [31:0] b_rdata;
  logic [15:0] b_fcnt;
  logic        c_ready, c_rvld, c_fault;
  logic [31:0] c_rdata;
  logic [15:0] c_fcnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] pd [8];

  data_mem_ctrl #(.ADDR_W(12), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_size(a_size), .req_signed(a_signed), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rvld), .rsp_rdata(a_rdata), .rsp_fault(a_fault), .fault_count(a_fcnt));

  data_mem_ctrl #(.ADDR_W(6), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_size(b_size), .req_signed(b_signed), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rvld), .rsp_rdata(b_rdata), .rsp_fault(b_fault), .fault_count(b_fcnt));

  data_mem_ctrl #(.ADDR_W(6), .READ_LAT(4)) dut_c (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(c_ready), .req_write(b_write),
    .req_size(b_size), .req_signed(b_signed), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(c_rvld), .rsp_rdata(c_rdata), .rsp_fault(c_fault), .fault_count(c_fcnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One request on port A; with READ_LAT=1 the response is visible just after the accept edge.
  task automatic a_op(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_flt);
    a_valid = 1'b1; a_write = w; a_size = sz; a_signed = sg; a_addr = ad; a_wdata = wd;
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk({tag, "_d"}, a_rdata, exp_rd);
    chk({tag, "_vf"}, {30'd0, a_rvld, a_fault}, {30'd0, 1'b1, exp_flt});
  endtask

  // One request on the shared B/C port; records the first response of each instance.
  task automatic b_op(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_flt);
    int lb, lc;
    logic [32:0] rb, rc;
    lb = -1; lc = -1; rb = '0; rc = '0;
    b_valid = 1'b1; b_write = w; b_size = sz; b_signed = sg; b_addr = ad; b_wdata = wd;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      if (s == 0) b_valid = 1'b0;
      if (b_rvld && lb < 0) begin lb = s; rb = {b_fault, b_rdata}; end
      if (c_rvld && lc < 0) begin lc = s; rc = {c_fault, c_rdata}; end
    end
    chk({tag, "_lat3"}, lb, 2);
    chk({tag, "_lat4"}, lc, 3);
    chk({tag, "_d3"}, rb[31:0], exp_rd);
    chk({tag, "_d4"}, rc[31:0], exp_rd);
    chk({tag, "_f3"}, rb[32], exp_flt);
    chk({tag, "_f4"}, rc[32], exp_flt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int cnt;
    logic seen_b, seen_c;
    rst = 1'b1; rst_b = 1'b1;
    a_valid = 0; a_write = 0; a_size = 0; a_signed = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_write = 0; b_size = 0; b_signed = 0; b_addr = 0; b_wdata = 0;
    for (int i = 0; i < 8; i++) pd[i] = 32'h1111_1111 * (i + 1);
    repeat (3) @(posedge clk); #1;

    chk("rst_ready",  a_ready, 0);
    chk("rst_rvld",   a_rvld,  0);
    chk("rst_rdata",  a_rdata, 0);
    chk("rst_fault",  a_fault, 0);
    chk("rst_fcnt",   a_fcnt,  0);
    chk("rst_rvld_c", c_rvld,  0);

    rst = 1'b0; rst_b = 1'b0;
    cnt = 0;
    while (!a_ready && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    chk("clear_len", cnt, 1024);

    a_op("ld_ffc",   0, 2'b10, 0, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 0);
    a_op("st_w",     1, 2'b10, 0, 32'h0000_0100, 32'hDEADBEEF,  32'h0,         0);
    a_op("st_b",     1, 2'b00, 0, 32'h0000_0102, 32'hFFFF_FF55, 32'h0,         0);
    a_op("ld_w",     0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'hDE55BEEF,  0);
    a_op("ld_sb",    0, 2'b00, 1, 32'h0000_0103, 32'h0,         32'hFFFFFFDE,  0);
    a_op("ld_uh",    0, 2'b01, 0, 32'h0000_0100, 32'h0,         32'h0000BEEF,  0);
    a_op("ld_sh",    0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'hFFFFDE55,  0);
    a_op("ld_ub",    0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'h000000DE,  0);
    a_op("ld_sbpos", 0, 2'b00, 1, 32'h0000_0102, 32'h0,         32'h00000055,  0);
    a_op("st_h",     1, 2'b01, 0, 32'h0000_0106, 32'hABCD_1234, 32'h0,         0);
    a_op("ld_w104",  0, 2'b10, 0, 32'h0000_0104, 32'h0,         32'h12340000,  0);
    a_op("ld_wsgn",  0, 2'b10, 1, 32'h0000_0100, 32'h0,         32'hDE55BEEF,  0);

    a_op("f_wmis",   0, 2'b10, 0, 32'h0000_0102, 32'h0,         32'h0, 1);
    a_op("f_hmis",   1, 2'b01, 0, 32'h0000_0101, 32'h0000_AAAA, 32'h0, 1);
    a_op("f_range",  0, 2'b00, 0, 32'h0000_1000, 32'h0,         32'h0, 1);
    a_op("f_size",   0, 2'b11, 0, 32'h0000_0000, 32'h0,         32'h0, 1);
    chk("fcnt4", a_fcnt, 4);
    a_op("ld_after_f", 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDE55BEEF, 0);
    @(posedge clk); #1;
    chk("idle_vld",   a_rvld,  0);
    chk("idle_rdata", a_rdata, 0);

    for (int i = 0; i < 8; i++) begin
      b_valid = 1; b_write = 1; b_size = 2'b10; b_signed = 0; b_addr = 32'(4 * i); b_wdata = pd[i];
      @(posedge clk); #1;
    end
    b_valid = 0;
    repeat (6) @(posedge clk); #1;

    // Back-to-back loads: response j is seen after edge j+LAT-1 of the issue loop.
    for (int s = 0; s <= 11; s++) begin
      int jb, jc;
      if (s < 8) begin
        b_valid = 1; b_write = 0; b_size = 2'b10; b_signed = 0; b_addr = 32'(4 * s);
      end else b_valid = 0;
      @(posedge clk); #1;
      jb = s - 2; jc = s - 3;
      chk($sformatf("pipe3_v%0d", s), b_rvld, (jb >= 0 && jb < 8) ? 1 : 0);
      chk($sformatf("pipe3_d%0d", s), b_rdata, (jb >= 0 && jb < 8) ? pd[jb] : 32'h0);
      chk($sformatf("pipe4_v%0d", s), c_rvld, (jc >= 0 && jc < 8) ? 1 : 0);
      chk($sformatf("pipe4_d%0d", s), c_rdata, (jc >= 0 && jc < 8) ? pd[jc] : 32'h0);
    end

    b_op("b_range", 0, 2'b00, 0, 32'h0000_0040, 32'h0, 32'h0, 1);
    b_op("b_hibit", 0, 2'b10, 0, 32'h8000_0000, 32'h0, 32'h0, 1);
    b_op("b_ld3",   0, 2'b10, 0, 32'h0000_000C, 32'h0, pd[3], 0);
    chk("b_fcnt2", b_fcnt, 2);
    chk("c_fcnt2", c_fcnt, 2);

    b_valid = 1; b_write = 0; b_size = 2'b10; b_signed = 0; b_addr = 32'h4;
    @(posedge clk); #1;
    b_valid = 0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    seen_b = 0; seen_c = 0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_b |= b_rvld; seen_c |= c_rvld;
    end
    chk("mid_rst_fcnt",  b_fcnt,  0);
    chk("mid_rst_ready", b_ready, 0);
    rst_b = 1'b0;
    cnt = 0;
    while (!b_ready && cnt < 100) begin
      @(posedge clk); #1; cnt++;
      seen_b |= b_rvld; seen_c |= c_rvld;
    end
    chk("flush3", seen_b, 0);
    chk("flush4", seen_c, 0);
    chk("b_clear_len", cnt, 16);
    b_op("b_wiped", 0, 2'b10, 0, 32'h0000_0004, 32'h0, 32'h0, 0);

    b_valid = 1; b_write = 0; b_size = 2'b11; b_addr = 32'h0;
    repeat (65535) @(posedge clk); #1;
    chk("sat_b_65535", b_fcnt, 32'hFFFF);
    chk("sat_c_65535", c_fcnt, 32'hFFFF);
    repeat (2) @(posedge clk); #1;
    b_valid = 0;
    chk("sat_b_65537", b_fcnt, 32'hFFFF);
    chk("sat_c_65537", c_fcnt, 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
